alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
- Multi-cycle issue/sequencing controller on the driving side of the 16-bit ALU.
- Accepts one instruction at a time over a valid/ready handshake and decodes it.
- Reads an internal 8x16 register file and drives the ALU's Operand1/Operand2/Alu_Opcode/Shift inputs.
- Captures Result/Zero_Out, then performs writeback, a data-memory access, or a PC update.

Parameters:
- PC_RESET, 16'h0000, PC value loaded on reset.
- R0_ZERO, 1, when 1: R0 reads as 0 and writes to R0 are discarded.

Ports:
- Clk  input  1  clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- Instr  input  16  instruction word.
- Instr_Valid  input  1  Instr is valid.
- Instr_Ready  output  1  controller can accept an instruction.
- Alu_Operand1  output  16  to ALU Operand1.
- Alu_Operand2  output  16  to ALU Operand2.
- Alu_Opcode  output  3  to ALU opcode.
- Alu_Shift  output  1  to ALU Shift (1 = right).
- Alu_Result  input  16  from ALU Result (combinational).
- Alu_Zero  input  1  from ALU Zero_Out.
- Mem_Req  output  1  data-memory request, held until Mem_Ack.
- Mem_We  output  1  1 = store, 0 = load; valid while Mem_Req.
- Mem_Addr  output  16  memory address.
- Mem_Wdata  output  16  store data.
- Mem_Rdata  input  16  load data, valid when Mem_Ack.
- Mem_Ack  input  1  one-cycle completion pulse.
- Pc  output  16  program counter.
- Done  output  1  one-cycle pulse when an instruction retires.
- Dbg_Addr  input  3  register-file debug read address.
- Dbg_Data  output  16  combinational read of reg[Dbg_Addr]; R0 reads 0 when R0_ZERO=1.

Behaviour:
- Reset values (async on Rst_n=0, in any state): all regs 0; Pc=PC_RESET; all outputs 0 except Instr_Ready=1; state IDLE.
  - An in-flight instruction is dropped; Mem_Req falls immediately.
- Instruction format:
  - op=[15:13], rd=[12:10], rs=[9:7], rt=[6:4], imm7=[6:0], dir=[4], amt=[3:0].
  - sext(imm7) is 16-bit sign extension.
- ALU drive per op, registered in OPER:
  - 000 ADD: Op1=rs, Op2=rt.
  - 001 ADDI: Op1=rs, Op2=sext(imm7).
  - 010 SHIFT / 011 ROT: Op1=rs, Op2=zext(amt), Alu_Shift=dir.
  - 100 BEQZ: Op1=rs, Op2=0.
  - 101 SW: Op1=rd, Op2=rs.
  - 110 LW: Op1=0, Op2=rs.
  - 111 JMP: Op1=rs, Op2=sext(imm7).
  - Alu_Opcode=op in all cases.
- ALU outputs are held stable from OPER until the instruction retires.
- FSM:
  - IDLE: Instr_Ready=1. On Instr_Valid, latch Instr; Instr_Ready drops next cycle -> OPER.
  - OPER: drive ALU operands -> EXEC.
  - EXEC: capture Alu_Result into res and Alu_Zero into z.
    - ops 000-011 -> WB.
    - 100/111 -> DONE.
    - 101/110 -> MEM.
  - MEM: Mem_Req=1, Mem_Addr=res, Mem_We=(op==101), Mem_Wdata=reg[rd]. Hold until Mem_Ack.
    - On Mem_Ack: LW -> WB (data=Mem_Rdata); SW -> DONE.
    - No timeout.
  - WB: reg[rd] <= res, or Mem_Rdata captured for LW; suppressed if rd==0 and R0_ZERO=1 -> DONE.
  - DONE: Done=1 for exactly one cycle; Pc updates on exiting DONE -> IDLE.
- Pc update:
  - Default Pc+1.
  - BEQZ: Pc+1+sext(imm7) if z=1, else Pc+1.
  - JMP: res.
  - All Pc arithmetic is mod 2^16 and wraps silently.
- Latency:
  - Accept edge at T: ALU op Done at T+4; BEQZ/JMP Done at T+3; SW Done 2 cycles after Mem_Ack; LW Done 3 cycles after Mem_Ack.
  - Next instruction can be accepted the cycle after Done.
- Boundary conditions:
  - Instr_Valid is ignored outside IDLE.
  - Mem_Ack outside MEM is ignored.
  - Source and destination may be the same register (e.g. ADD R1,R1,R1); operands are read in OPER, before WB.

Test Plan:
- Reset then ADD: R2=3, R3=5 (preloaded via ADDI from R0), then ADD R1,R2,R3 -> Dbg(1)=8, Done 4 cycles after accept, Pc=3.
- ADDI R1,R0,-1 (imm7=7'h7F) -> R1=16'hFFFF. ROT right amt=4 -> FFFF. SHIFT left amt=15 on R1=1 -> 16'h8000. Write to R0 -> Dbg(0)=0.
- BEQZ R0 imm=+5 at Pc=10 -> Pc=16. BEQZ R1 (R1=1) -> Pc=11. JMP R2=16'hFFFF imm=+2 -> Pc=16'h0001 (wrap).
- SW R1->[R2] with Mem_Ack delayed 3 cycles: Mem_Req held 4 cycles, Mem_Addr=R2, Mem_Wdata=R1, Mem_We=1. LW R4<-[R2] with Rdata=16'hBEEF -> Dbg(4)=BEEF.
- Instr_Valid held high through a busy instruction: only one accept; a second accept occurs the cycle after Done.
- Rst_n low during MEM: Mem_Req drops asynchronously, Pc=PC_RESET, all regs 0, Instr_Ready=1 after release.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle issue/sequencing controller that sits on the
// driving side of a 16-bit ALU. It takes one instruction at a time over a
// valid/ready handshake, reads operands from an internal 8x16 register file,
// drives the ALU inputs, captures Result/Zero, then performs a writeback,
// a data-memory access, or a PC update.
//
// Ports:
//   Clk, Rst_n                 clock (rising edge), async active-low reset
//   Instr/Instr_Valid/Ready    instruction handshake
//   Alu_Operand1/2, Alu_Opcode,
//   Alu_Shift                  registered ALU drive, held until retire
//   Alu_Result, Alu_Zero       combinational ALU outputs
//   Mem_Req/We/Addr/Wdata      data-memory request, held until Mem_Ack
//   Mem_Rdata, Mem_Ack         load data / one-cycle completion pulse
//   Pc                         program counter
//   Done                       one-cycle retire pulse
//   Dbg_Addr, Dbg_Data         combinational register-file read port
module alu_issue_ctrl #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter bit          R0_ZERO  = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [15:0] Instr,
  input  logic        Instr_Valid,
  output logic        Instr_Ready,
  output logic [15:0] Alu_Operand1,
  output logic [15:0] Alu_Operand2,
  output logic [2:0]  Alu_Opcode,
  output logic        Alu_Shift,
  input  logic [15:0] Alu_Result,
  input  logic        Alu_Zero,
  output logic        Mem_Req,
  output logic        Mem_We,
  output logic [15:0] Mem_Addr,
  output logic [15:0] Mem_Wdata,
  input  logic [15:0] Mem_Rdata,
  input  logic        Mem_Ack,
  output logic [15:0] Pc,
  output logic        Done,
  input  logic [2:0]  Dbg_Addr,
  output logic [15:0] Dbg_Data
);

  typedef enum logic [2:0] {
    S_IDLE, S_OPER, S_EXEC, S_MEM, S_WB, S_DONE
  } state_t;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_ADDI  = 3'd1;
  localparam logic [2:0] OP_SHIFT = 3'd2;
  localparam logic [2:0] OP_ROT   = 3'd3;
  localparam logic [2:0] OP_BEQZ  = 3'd4;
  localparam logic [2:0] OP_SW    = 3'd5;
  localparam logic [2:0] OP_LW    = 3'd6;
  localparam logic [2:0] OP_JMP   = 3'd7;

  state_t      r_state;
  logic [15:0] r_instr;
  logic [15:0] r_res;
  logic        r_z;
  logic [15:0] r_rf [8];

  logic [2:0]  w_op, w_rd, w_rs, w_rt;
  logic [15:0] w_imm_sext, w_amt_zext;
  logic        w_dir;
  logic [15:0] w_rd_val, w_rs_val, w_rt_val;
  logic [15:0] w_pc_inc, w_pc_next;
  logic        w_wb_en;

  assign w_op       = r_instr[15:13];
  assign w_rd       = r_instr[12:10];
  assign w_rs       = r_instr[9:7];
  assign w_rt       = r_instr[6:4];
  assign w_dir      = r_instr[4];
  assign w_imm_sext = {{9{r_instr[6]}}, r_instr[6:0]};
  assign w_amt_zext = {12'h000, r_instr[3:0]};

  // R0 is hardwired to zero on every read port when R0_ZERO is set
  assign w_rd_val = (R0_ZERO && w_rd == 3'd0)     ? 16'h0000 : r_rf[w_rd];
  assign w_rs_val = (R0_ZERO && w_rs == 3'd0)     ? 16'h0000 : r_rf[w_rs];
  assign w_rt_val = (R0_ZERO && w_rt == 3'd0)     ? 16'h0000 : r_rf[w_rt];
  assign Dbg_Data = (R0_ZERO && Dbg_Addr == 3'd0) ? 16'h0000 : r_rf[Dbg_Addr];

  assign w_wb_en  = !(R0_ZERO && w_rd == 3'd0);
  assign w_pc_inc = Pc + 16'd1;

  always_comb begin
    w_pc_next = w_pc_inc;
    case (w_op)
      OP_BEQZ: if (r_z) w_pc_next = w_pc_inc + w_imm_sext;
      OP_JMP:  w_pc_next = r_res;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state      <= S_IDLE;
      r_instr      <= '0;
      r_res        <= '0;
      r_z          <= 1'b0;
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
      Instr_Ready  <= 1'b1;
      Alu_Operand1 <= '0;
      Alu_Operand2 <= '0;
      Alu_Opcode   <= '0;
      Alu_Shift    <= 1'b0;
      Mem_Req      <= 1'b0;
      Mem_We       <= 1'b0;
      Mem_Addr     <= '0;
      Mem_Wdata    <= '0;
      Pc           <= PC_RESET;
      Done         <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Instr_Valid) begin
            r_instr     <= Instr;
            Instr_Ready <= 1'b0;
            r_state     <= S_OPER;
          end
        end
        S_OPER: begin
          // ALU drive stays put from here until retire
          Alu_Opcode   <= w_op;
          Alu_Shift    <= 1'b0;
          Alu_Operand1 <= w_rs_val;
          case (w_op)
            OP_ADD:           Alu_Operand2 <= w_rt_val;
            OP_ADDI, OP_JMP:  Alu_Operand2 <= w_imm_sext;
            OP_SHIFT, OP_ROT: begin
              Alu_Operand2 <= w_amt_zext;
              Alu_Shift    <= w_dir;
            end
            OP_BEQZ:          Alu_Operand2 <= '0;
            OP_SW: begin
              Alu_Operand1 <= w_rd_val;
              Alu_Operand2 <= w_rs_val;
            end
            default: begin  // LW
              Alu_Operand1 <= '0;
              Alu_Operand2 <= w_rs_val;
            end
          endcase
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_res <= Alu_Result;
          r_z   <= Alu_Zero;
          case (w_op)
            OP_BEQZ, OP_JMP: begin
              Done    <= 1'b1;
              r_state <= S_DONE;
            end
            OP_SW, OP_LW: begin
              Mem_Req   <= 1'b1;
              Mem_We    <= (w_op == OP_SW);
              Mem_Addr  <= Alu_Result;
              Mem_Wdata <= w_rd_val;
              r_state   <= S_MEM;
            end
            default: r_state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (Mem_Ack) begin
            Mem_Req <= 1'b0;
            Mem_We  <= 1'b0;
            if (w_op == OP_LW) begin
              r_res   <= Mem_Rdata;  // load data reuses the writeback path
              r_state <= S_WB;
            end else begin
              Done    <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_WB: begin
          if (w_wb_en) r_rf[w_rd] <= r_res;
          Done    <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          Pc          <= w_pc_next;
          Instr_Ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
